intensity: RTL and testbench

INTENSITY -- requirements
Module: intensity

---
 rtl/intensity.sv | 63 ++++++
 tb/tb_intensity.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/intensity.sv
// Purpose : converts a 3x3 grid of RGB pixels into a registered grid of 8-bit
//           intensities, I = floor((R + 2G + B) / 4), all nine in parallel.
// Latency : 1 cycle from a qualifying intensity_enable edge to iGrid.
// Backpressure: edgedetect_enable freezes iGrid while the edge detector reads it;
//           there is no busy state, so every qualifying enable loads a fresh result.
// Ports:
//   clk               - single clock, rising edge
//   n_rst             - synchronous active-high reset, clears iGrid
//   pixelData         - 9 x 24-bit RGB pixels, pixel 0 in the top bits, R upper byte
//   intensity_enable  - load request
//   edgedetect_enable - downstream is reading iGrid, hold it stable
//   iGrid             - 9 x 8-bit intensities, I_0 in the top bits
module intensity #(
  parameter int NUM_PIX = 9,
  parameter int PIX_W   = 8
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [NUM_PIX*3*PIX_W-1:0] pixelData,
  input  logic                       intensity_enable,
  input  logic                       edgedetect_enable,
  output logic [NUM_PIX*PIX_W-1:0]   iGrid
);

  // Two extra bits hold R + 2G + B without overflow.
  localparam int SUM_W = PIX_W + 2;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  logic [NUM_PIX*PIX_W-1:0] grid_next;
  logic                     load;

  always_comb begin
    rgb_t             pix;
    logic [SUM_W-1:0] sum;
    grid_next = '0;
    pix       = '0;
    sum       = '0;
    for (int k = 0; k < NUM_PIX; k++) begin
      // Pixel 0 sits in the most significant slot of both buses.
      pix = rgb_t'(pixelData[(NUM_PIX-1-k)*3*PIX_W +: 3*PIX_W]);
      sum = SUM_W'(pix.r) + SUM_W'({pix.g, 1'b0}) + SUM_W'(pix.b);
      // Max sum is 4*(2^PIX_W - 1), so the shifted value always fits PIX_W bits.
      grid_next[(NUM_PIX-1-k)*PIX_W +: PIX_W] = PIX_W'(sum >> 2);
    end
  end

  // The edge detector read has priority over a new load.
  assign load = intensity_enable && !edgedetect_enable;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      iGrid <= '0;
    end else if (load) begin
      iGrid <= grid_next;
    end
  end

endmodule

// File: tb/tb_intensity.sv
// Purpose : directed and random checks of the intensity grid register.
// Latency : expects iGrid to reflect a load one edge after it is driven.
// Backpressure: exercises edgedetect_enable freeze against intensity_enable.
module tb_intensity;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [215:0] pixelData;
  logic         intensity_enable;
  logic         edgedetect_enable;
  logic [71:0]  iGrid;

  int checks   = 0;
  int failures = 0;

  logic [71:0] exp_q[$];
  string       tag_q[$];
  logic [71:0] model;

  localparam logic [215:0] KNOWN_PIX =
    216'h1414283C50647890A005162A416364D2C8A40C18303C4854609BBD;
  localparam logic [71:0]  KNOWN_GRID = 72'h19508E165AC11B4894;

  always #5 clk = ~clk;

  intensity #(.NUM_PIX(9), .PIX_W(8)) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .pixelData         (pixelData),
    .intensity_enable  (intensity_enable),
    .edgedetect_enable (edgedetect_enable),
    .iGrid             (iGrid)
  );

  function automatic logic [71:0] ref_grid(input logic [215:0] p);
    logic [71:0] g;
    int r, gr, b, s;
    g = '0;
    for (int k = 0; k < 9; k++) begin
      r  = int'(p[215-24*k -: 8]);
      gr = int'(p[207-24*k -: 8]);
      b  = int'(p[199-24*k -: 8]);
      s  = r + 2 * gr + b;
      g[71-8*k -: 8] = 8'(s / 4);
    end
    return g;
  endfunction

  // Drive one cycle of stimulus, push the expected grid, then compare after the edge.
  task automatic step(input logic rst, input logic en, input logic ed,
                      input logic [215:0] pix, input string tag);
    logic [71:0] e;
    string       t;
    @(negedge clk);
    n_rst             = rst;
    intensity_enable  = en;
    edgedetect_enable = ed;
    pixelData         = pix;
    if (rst)            model = '0;
    else if (en && !ed) model = ref_grid(pix);
    exp_q.push_back(model);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (iGrid === e) else begin
      failures++;
      $error("FAIL %s: iGrid=%h expected=%h", t, iGrid, e);
    end
  endtask

  // Independent constant check on the current output.
  task automatic check_const(input logic [71:0] e, input string tag);
    checks++;
    assert (iGrid === e) else begin
      failures++;
      $error("FAIL %s: iGrid=%h expected=%h", tag, iGrid, e);
    end
  endtask

  initial begin
    logic [215:0] rp;
    logic [215:0] ones;
    n_rst = 1'b1;
    intensity_enable = 1'b0;
    edgedetect_enable = 1'b0;
    pixelData = '0;
    model = '0;
    ones = '1;

    // Reset wins over a pending load of all-ones pixels.
    step(1'b1, 1'b1, 1'b0, ones, "reset_with_enable");
    check_const(72'h0, "reset_zero_const");
    // Stays zero after reset until a qualifying load.
    step(1'b0, 1'b0, 1'b0, ones, "post_reset_idle");

    // Known grid.
    step(1'b0, 1'b1, 1'b0, KNOWN_PIX, "known_grid");
    check_const(KNOWN_GRID, "known_grid_const");

    // Hold with pixelData changing, then X.
    step(1'b0, 1'b0, 1'b0, ones, "hold_1");
    step(1'b0, 1'b0, 1'b0, ones, "hold_2");
    step(1'b0, 1'b0, 1'b0, ones, "hold_3");
    step(1'b0, 1'b0, 1'b0, 'x,   "hold_x");
    check_const(KNOWN_GRID, "hold_const");

    // Saturation boundaries.
    step(1'b0, 1'b1, 1'b0, ones, "sat_ones");
    check_const({9{8'hFF}}, "sat_ones_const");
    step(1'b0, 1'b1, 1'b0, '0, "sat_zero");
    check_const(72'h0, "sat_zero_const");

    // Freeze while the edge detector reads, then update.
    step(1'b0, 1'b1, 1'b0, KNOWN_PIX, "pre_freeze_load");
    step(1'b0, 1'b1, 1'b1, ones, "freeze");
    check_const(KNOWN_GRID, "freeze_const");
    step(1'b0, 1'b1, 1'b0, ones, "unfreeze");
    check_const({9{8'hFF}}, "unfreeze_const");

    // Back-to-back loads with changing pixels.
    step(1'b0, 1'b1, 1'b0, KNOWN_PIX, "b2b_first");
    step(1'b0, 1'b1, 1'b0, {9{24'h10_20_30}}, "b2b_second");
    // (16 + 64 + 48) / 4 = 32
    check_const({9{8'h20}}, "b2b_second_const");

    // Random mix of enables and pixels.
    for (int i = 0; i < 40; i++) begin
      rp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), rp, "random");
    end

    // Reset in the same cycle as a load discards it.
    step(1'b1, 1'b1, 1'b0, KNOWN_PIX, "reset_discards_load");
    step(1'b0, 1'b0, 1'b0, KNOWN_PIX, "post_reset_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
